// File: rtl/wb_traffic_master_pkg.sv
// Shared definitions for the WISHBONE traffic master: CTI codes, FSM encoding and LFSR helpers.
package wb_traffic_master_pkg;

    localparam logic [2:0] CtiClassic = 3'b000;
    localparam logic [2:0] CtiIncr    = 3'b010;
    localparam logic [2:0] CtiEnd     = 3'b111;

    // Galois form of x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LfsrPoly = 32'h8020_0003;

    typedef enum logic [2:0] {
        StIdle,
        StGen,
        StReq,
        StBus,
        StBackoff,
        StDone
    } state_e;

    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        lfsr_next = {1'b0, cur[31:1]} ^ (cur[0] ? LfsrPoly : 32'h0);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] val);
        sat_inc = (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

endpackage

// File: rtl/wb_tg_lfsr.sv
// 32-bit Galois LFSR with single-step advance and snapshot reload; load wins over advance.
module wb_tg_lfsr
    import wb_traffic_master_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    input  logic        load,
    input  logic [31:0] load_value,
    output logic [31:0] value
);

    logic [31:0] value_q;
    logic [31:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_value;
        end else if (advance) begin
            value_d = lfsr_next(value_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= SEED;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/wb_traffic_master.sv
// WISHBONE B4 traffic master: LFSR-driven reads, single writes and incrementing bursts with
// retry back-off, error accounting, STALL handling, arbiter request and bounded run length.
module wb_traffic_master
    import wb_traffic_master_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           SEL_WIDTH  = DATA_WIDTH / 8,
    parameter int unsigned           MAX_BURST  = 8,
    parameter int unsigned           READ_PCT   = 50,
    parameter int unsigned           SMALL_PCT  = 50,
    parameter int unsigned           MAX_RETRY  = 3,
    parameter int unsigned           N_TRANS    = 0,
    parameter logic [31:0]           SEED       = 32'hACE1_0001,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [31:0]           ADDR_MASK  = 32'h0000_0FFC
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  CYC_O,
    output logic                  STB_O,
    output logic                  WE_O,
    output logic [ADDR_WIDTH-1:0] ADR_O,
    output logic [DATA_WIDTH-1:0] DAT_O,
    output logic [SEL_WIDTH-1:0]  SEL_O,
    output logic [2:0]            CTI_O,
    input  logic [DATA_WIDTH-1:0] DAT_I,
    input  logic                  ACK_I,
    input  logic                  RTY_I,
    input  logic                  ERR_I,
    input  logic                  STALL_I,
    output logic                  req_wb_o,
    input  logic                  gnt_wb_i,
    input  logic                  enable_i,
    output logic                  rd_valid_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  done_o,
    output logic [15:0]           n_read_o,
    output logic [15:0]           n_write_o,
    output logic [15:0]           n_err_o,
    output logic [15:0]           n_rty_o
);

    localparam int unsigned BeatW = 5;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(MAX_BURST - 1);

    state_e state_q, state_d;

    logic [31:0]           snap_q, snap_d;
    logic                  is_read_q, is_read_d;
    logic                  is_single_q, is_single_d;
    logic [BeatW-1:0]      beat_q, beat_d;
    logic [31:0]           retry_q, retry_d;
    logic [3:0]            backoff_q, backoff_d;
    logic [31:0]           trans_q, trans_d;
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [15:0]           n_read_q, n_write_q, n_err_q, n_rty_q;

    logic        lfsr_adv, lfsr_load;
    logic [31:0] lfsr;
    logic        ev_read, ev_write, ev_err, ev_rty, rd_fire, finish;
    logic        last_beat, in_bus;

    logic [ADDR_WIDTH-1:0] rand_addr, beat_addr;
    logic [DATA_WIDTH-1:0] bus_data;

    wb_tg_lfsr #(
        .SEED(SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .advance   (lfsr_adv),
        .load      (lfsr_load),
        .load_value(snap_q),
        .value     (lfsr)
    );

    // Address and data are built bit by bit so any bus width works off the 32-bit LFSR.
    always_comb begin
        rand_addr = '0;
        for (int i = 0; i < int'(ADDR_WIDTH) && i < 32; i++) begin
            rand_addr[i] = snap_q[i] & ADDR_MASK[i];
        end
    end

    always_comb begin
        bus_data = '0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            bus_data[i] = lfsr[i % 32];
        end
    end

    assign beat_addr = (BASE_ADDR | rand_addr) + ADDR_WIDTH'(beat_q) * ADDR_WIDTH'(SEL_WIDTH);
    assign last_beat = is_single_q || (beat_q == LastBeat);

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        is_read_d   = is_read_q;
        is_single_d = is_single_q;
        beat_d      = beat_q;
        retry_d     = retry_q;
        backoff_d   = backoff_q;
        trans_d     = trans_q;
        lfsr_adv    = 1'b0;
        lfsr_load   = 1'b0;
        ev_read     = 1'b0;
        ev_write    = 1'b0;
        ev_err      = 1'b0;
        ev_rty      = 1'b0;
        rd_fire     = 1'b0;
        finish      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable_i) begin
                    state_d = StGen;
                end
            end
            StGen: begin
                snap_d      = lfsr;
                is_read_d   = (32'(lfsr[7:0]) % 32'd100) < READ_PCT;
                is_single_d = is_read_d || ((32'(lfsr[15:8]) % 32'd100) < SMALL_PCT);
                beat_d      = '0;
                retry_d     = '0;
                state_d     = StReq;
            end
            StReq: begin
                if (gnt_wb_i) begin
                    state_d = StBus;
                end
            end
            StBus: begin
                if (!STALL_I) begin
                    if (ERR_I || (RTY_I && retry_q >= MAX_RETRY)) begin
                        // Step past the failed data so the next draw is a fresh transaction.
                        ev_err   = 1'b1;
                        lfsr_adv = 1'b1;
                        finish   = 1'b1;
                    end else if (RTY_I) begin
                        ev_rty    = 1'b1;
                        retry_d   = retry_q + 32'd1;
                        lfsr_load = 1'b1;
                        beat_d    = '0;
                        backoff_d = snap_q[3:0];
                        state_d   = StBackoff;
                    end else if (ACK_I) begin
                        lfsr_adv = 1'b1;
                        rd_fire  = is_read_q;
                        if (last_beat) begin
                            ev_read  = is_read_q;
                            ev_write = !is_read_q;
                            finish   = 1'b1;
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end
                end
            end
            StBackoff: begin
                if (backoff_q == 4'd0) begin
                    state_d = StReq;
                end else begin
                    backoff_d = backoff_q - 4'd1;
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (finish) begin
            trans_d = trans_q + 32'd1;
            if (N_TRANS != 0 && trans_d >= N_TRANS) begin
                state_d = StDone;
            end else if (enable_i) begin
                state_d = StGen;
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            snap_q      <= '0;
            is_read_q   <= 1'b0;
            is_single_q <= 1'b0;
            beat_q      <= '0;
            retry_q     <= '0;
            backoff_q   <= '0;
            trans_q     <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            n_read_q    <= '0;
            n_write_q   <= '0;
            n_err_q     <= '0;
            n_rty_q     <= '0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            is_read_q   <= is_read_d;
            is_single_q <= is_single_d;
            beat_q      <= beat_d;
            retry_q     <= retry_d;
            backoff_q   <= backoff_d;
            trans_q     <= trans_d;
            rd_valid_q  <= rd_fire;
            if (rd_fire) begin
                rd_data_q <= DAT_I;
            end
            if (ev_read) begin
                n_read_q <= sat_inc(n_read_q);
            end
            if (ev_write) begin
                n_write_q <= sat_inc(n_write_q);
            end
            if (ev_err) begin
                n_err_q <= sat_inc(n_err_q);
            end
            if (ev_rty) begin
                n_rty_q <= sat_inc(n_rty_q);
            end
        end
    end

    assign in_bus = (state_q == StBus);

    always_comb begin
        CYC_O    = in_bus;
        STB_O    = in_bus;
        WE_O     = in_bus && !is_read_q;
        ADR_O    = in_bus ? beat_addr : '0;
        DAT_O    = in_bus ? bus_data : '0;
        SEL_O    = in_bus ? '1 : '0;
        CTI_O    = CtiClassic;
        if (in_bus && !is_single_q) begin
            CTI_O = (beat_q == LastBeat) ? CtiEnd : CtiIncr;
        end
        req_wb_o = (state_q == StReq) || in_bus;
        done_o   = (state_q == StDone);
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign n_read_o   = n_read_q;
    assign n_write_o  = n_write_q;
    assign n_err_o    = n_err_q;
    assign n_rty_o    = n_rty_q;

endmodule
